muldiv_unit: RTL and testbench
==============================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 Parameter WIDTH, default 32, operand and result width in bits.
REQ-002 Parameter MULT_CYC, default 5, cycles busy is high for MULT/MULTU (legal 1..15).
REQ-003 Parameter DIV_CYC, default 10, cycles busy is high for DIV/DIVU (legal 1..15).
REQ-004 Port clk  in  1  sole clock; all state updates on the rising edge.
REQ-005 Port rst_n  in  1  reset, asynchronous, active-low.
REQ-006 Port start  in  1  request; sampled on the rising edge of clk.
REQ-007 Port op  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 110/111 reserved.
REQ-008 Port A  in  WIDTH  first operand (multiplicand/dividend/move source).
REQ-009 Port B  in  WIDTH  second operand (multiplier/divisor).
REQ-010 Port busy  out  1  operation in progress; new requests ignored.
REQ-011 Port done  out  1  single-cycle pulse; an arithmetic result has just been committed.
REQ-012 Port hi  out  WIDTH  HI register (product upper half / remainder).
REQ-013 Port lo  out  WIDTH  LO register (product lower half / quotient).

Function
REQ-014 The block SHALL implement the states IDLE and RUN.
REQ-015 A request SHALL be accepted only when start=1 and busy=0 on a rising edge.
REQ-016 In IDLE, an accepted arithmetic op SHALL latch A, B and op, load the counter with MULT_CYC or DIV_CYC, and enter RUN.
REQ-017 busy SHALL be 1 for exactly N consecutive cycles starting the cycle after acceptance, where N is MULT_CYC or DIV_CYC.
REQ-018 hi and lo SHALL hold their prior values while busy=1.
REQ-019 On the edge ending the last busy cycle, the block SHALL update hi/lo, return to IDLE, and assert done for that one following cycle.
REQ-020 MULT SHALL compute a signed 2*WIDTH product: hi=upper WIDTH bits, lo=lower WIDTH bits.
REQ-021 MULTU SHALL compute the same split on an unsigned product.
REQ-022 DIV SHALL produce a signed quotient truncated toward zero into lo, with the remainder in hi carrying the dividend's sign.
REQ-023 DIVU SHALL produce an unsigned quotient into lo and the remainder into hi.
REQ-024 For division by zero (B=0), DIV and DIVU SHALL set lo=all ones and hi=A; no error flag.
REQ-025 For DIV with A=most-negative and B=-1, the block SHALL set lo=A and hi=0.
REQ-026 MTHI/MTLO accepted in IDLE SHALL write A into hi/lo on the accepting edge; busy and done stay 0.
REQ-027 Reserved ops SHALL be ignored (no state change, no done).
REQ-028 start while busy=1 SHALL be ignored, not queued; latched operands SHALL NOT change.
REQ-029 Operand changes on A/B/op after acceptance SHALL NOT affect the result.
REQ-030 A request accepted in the cycle done=1 (busy=0) SHALL be honoured, giving back-to-back operations.
REQ-031 Outputs SHALL depend only on registered state (no combinational path from inputs to busy/done/hi/lo).

Reset
REQ-032 rst_n=0 SHALL immediately, independent of clk, force state IDLE, busy=0, done=0, hi=0, lo=0, and clear the counter.
REQ-033 Reset during RUN SHALL abort the operation with no done pulse and no result commit.
REQ-034 After rst_n deasserts, the first rising edge SHALL be able to accept a request.

Verification
REQ-035 WIDTH=32: MULT A=0xFFFFFFFF, B=2 -> after 5 busy cycles hi=0xFFFFFFFF, lo=0xFFFFFFFE, done pulses once.
REQ-036 MULTU A=0xFFFFFFFF, B=2 -> hi=0x00000001, lo=0xFFFFFFFE.
REQ-037 DIV A=-7, B=2 -> after 10 busy cycles lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1); DIVU A=7, B=0 -> lo=0xFFFFFFFF, hi=7.
REQ-038 DIV A=0x80000000, B=0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-039 Start MULT, pulse start with DIV at busy cycle 2, and pull rst_n low at busy cycle 3 -> DIV ignored, all outputs 0 at once, no done.
REQ-040 MTLO A=0x1234 in IDLE -> lo=0x1234 next cycle, busy=0; MULT issued on the done cycle of a prior op -> accepted, busy rises the next cycle.

Source files
------------

// File: rtl/muldiv_unit.sv
// Multi-cycle multiply/divide unit with HI/LO result registers.
// Fixed-latency arithmetic; MTHI/MTLO write in a single cycle.
module muldiv_unit #(
  parameter int WIDTH    = 32,
  parameter int MULT_CYC = 5,
  parameter int DIV_CYC  = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  localparam logic [3:0] MCYC = 4'(MULT_CYC);
  localparam logic [3:0] DCYC = 4'(DIV_CYC);

  state_t             state, state_n;
  logic [3:0]         cnt, cnt_n;
  logic [2:0]         op_q, op_n;
  logic [WIDTH-1:0]   a_q, a_n;
  logic [WIDTH-1:0]   b_q, b_n;
  logic [WIDTH-1:0]   hi_n, lo_n;
  logic               done_n;
  logic [WIDTH-1:0]   res_hi, res_lo;

  logic signed [2*WIDTH-1:0] sa, sb, sprod;
  logic        [2*WIDTH-1:0] ua, ub, uprod;
  logic signed [WIDTH-1:0]   sdd, sdv, sq, sr;
  logic        [WIDTH-1:0]   udv, uq, ur;
  logic                      bzero, ovf;

  assign bzero = (b_q == '0);
  assign ovf   = (a_q == {1'b1, {(WIDTH-1){1'b0}}})
               && (b_q == '1);

  assign sa    = {{WIDTH{a_q[WIDTH-1]}}, a_q};
  assign sb    = {{WIDTH{b_q[WIDTH-1]}}, b_q};
  assign sprod = sa * sb;
  assign ua    = {{WIDTH{1'b0}}, a_q};
  assign ub    = {{WIDTH{1'b0}}, b_q};
  assign uprod = ua * ub;

  // Divisor forced to 1 on the special cases so the
  // dividers never see zero or overflow; result is overridden.
  assign sdd = a_q;
  assign sdv = (bzero || ovf) ? WIDTH'(1) : b_q;
  assign sq  = sdd / sdv;
  assign sr  = sdd % sdv;
  assign udv = bzero ? WIDTH'(1) : b_q;
  assign uq  = a_q / udv;
  assign ur  = a_q % udv;

  always_comb begin
    res_hi = hi;
    res_lo = lo;
    case (op_q)
      OP_MULT:  {res_hi, res_lo} = sprod;
      OP_MULTU: {res_hi, res_lo} = uprod;
      OP_DIV: begin
        if (bzero) begin
          res_hi = a_q;
          res_lo = '1;
        end else if (ovf) begin
          res_hi = '0;
          res_lo = a_q;
        end else begin
          res_hi = sr;
          res_lo = sq;
        end
      end
      OP_DIVU: begin
        if (bzero) begin
          res_hi = a_q;
          res_lo = '1;
        end else begin
          res_hi = ur;
          res_lo = uq;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    op_n    = op_q;
    a_n     = a_q;
    b_n     = b_q;
    hi_n    = hi;
    lo_n    = lo;
    done_n  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          case (op)
            OP_MULT, OP_MULTU: begin
              op_n    = op;
              a_n     = A;
              b_n     = B;
              cnt_n   = MCYC;
              state_n = RUN;
            end
            OP_DIV, OP_DIVU: begin
              op_n    = op;
              a_n     = A;
              b_n     = B;
              cnt_n   = DCYC;
              state_n = RUN;
            end
            OP_MTHI: hi_n = A;
            OP_MTLO: lo_n = A;
            default: ;
          endcase
        end
      end
      RUN: begin
        if (cnt <= 4'd1) begin
          hi_n    = res_hi;
          lo_n    = res_lo;
          done_n  = 1'b1;
          cnt_n   = '0;
          state_n = IDLE;
        end else begin
          cnt_n = cnt - 4'd1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      op_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      hi    <= '0;
      lo    <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      op_q  <= op_n;
      a_q   <= a_n;
      b_q   <= b_n;
      hi    <= hi_n;
      lo    <= lo_n;
      done  <= done_n;
    end
  end

  assign busy = (state == RUN);

endmodule

// File: tb/tb_muldiv_unit.sv
// Randomized self-checking bench for muldiv_unit against a
// 64-bit arithmetic reference model of HI/LO.
module tb_muldiv_unit;

  localparam int W    = 32;
  localparam int MCYC = 5;
  localparam int DCYC = 10;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [2:0]   op;
  logic [W-1:0] A, B;
  logic         busy, done;
  logic [W-1:0] hi, lo;

  int total = 0;
  int bad   = 0;
  logic [W-1:0] mhi = '0;
  logic [W-1:0] mlo = '0;

  muldiv_unit #(
    .WIDTH(W), .MULT_CYC(MCYC), .DIV_CYC(DCYC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op),
    .A(A), .B(B), .busy(busy), .done(done),
    .hi(hi), .lo(lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] model(
    input logic [2:0] o, input logic [31:0] a, input logic [31:0] b
  );
    longint sa, sb, q, rm, p;
    logic [63:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r  = {mhi, mlo};
    case (o)
      3'd0: begin
        p = sa * sb;
        r = 64'(p);
      end
      3'd1: r = {32'h0, a} * {32'h0, b};
      3'd2: begin
        if (b == 0) r = {a, 32'hffffffff};
        else if (a == 32'h80000000 && b == 32'hffffffff)
          r = {32'h0, a};
        else begin
          q  = sa / sb;
          rm = sa % sb;
          r  = {rm[31:0], q[31:0]};
        end
      end
      3'd3: begin
        if (b == 0) r = {a, 32'hffffffff};
        else r = {a % b, a / b};
      end
      default: ;
    endcase
    return r;
  endfunction

  // Called at a negedge; drives the request for the next posedge.
  task automatic run_op(
    input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
    input int inject, input bit chain, input string name
  );
    int n, cyc;
    logic [63:0] exp;
    bit hold_bad;
    n   = (o < 3'd2) ? MCYC : DCYC;
    exp = model(o, a, b);
    start = 1'b1; op = o; A = a; B = b;
    @(negedge clk);
    start = 1'b0;
    op = 3'($urandom); A = $urandom; B = $urandom;
    cyc = 0;
    hold_bad = 0;
    while (busy === 1'b1 && cyc < 40) begin
      cyc++;
      if (hi !== mhi || lo !== mlo || done !== 1'b0) hold_bad = 1;
      start = (cyc == inject);
      if (start) begin
        op = 3'(2 + $urandom_range(0, 1));
        A = $urandom; B = $urandom;
      end
      @(negedge clk);
    end
    start = 1'b0;
    total++;
    if (cyc != n) begin
      bad++;
      $display("FAIL %s busy_len got=%0d exp=%0d", name, cyc, n);
    end
    total++;
    if (hold_bad) begin
      bad++;
      $display("FAIL %s hold got=changed exp=held", name);
    end
    mhi = exp[63:32];
    mlo = exp[31:0];
    total++;
    if (done !== 1'b1) begin
      bad++;
      $display("FAIL %s done got=%b exp=1", name, done);
    end
    total++;
    if ({hi, lo} !== exp) begin
      bad++;
      $display("FAIL %s result got=%h_%h exp=%h", name, hi, lo, exp);
    end
    if (!chain) begin
      @(negedge clk);
      total++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        bad++;
        $display("FAIL %s done_once got=%b%b exp=00", name, done, busy);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1; start = 1'b0; op = '0; A = '0; B = '0;
    #1 rst_n = 1'b0;
    #1;
    total++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL reset_ctl got=%b%b exp=00", busy, done);
    end
    total++;
    if (hi !== '0 || lo !== '0) begin
      bad++;
      $display("FAIL reset_hilo got=%h_%h exp=0_0", hi, lo);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    run_op(3'd0, 32'hffffffff, 32'd2, 0, 0, "mult_neg");
    run_op(3'd1, 32'hffffffff, 32'd2, 0, 0, "multu");
    run_op(3'd2, -32'sd7, 32'd2, 0, 0, "div_neg");
    run_op(3'd3, 32'd7, 32'd0, 0, 0, "divu_zero");
    run_op(3'd2, 32'h80000000, 32'hffffffff, 0, 0, "div_ovf");
    run_op(3'd2, 32'd100, 32'd0, 0, 0, "div_zero");
  endtask

  task automatic test_move();
    logic [31:0] v;
    start = 1'b1; op = 3'd5; A = 32'h1234;
    @(negedge clk);
    start = 1'b0;
    mlo = 32'h1234;
    total++;
    if (lo !== mlo || hi !== mhi || busy !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL mtlo got=%h_%h %b%b exp=%h_%h 00",
               hi, lo, busy, done, mhi, mlo);
    end
    v = $urandom;
    start = 1'b1; op = 3'd4; A = v;
    @(negedge clk);
    start = 1'b0;
    mhi = v;
    total++;
    if (hi !== mhi || lo !== mlo || busy !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL mthi got=%h_%h %b%b exp=%h_%h 00",
               hi, lo, busy, done, mhi, mlo);
    end
  endtask

  task automatic test_reserved();
    for (int k = 6; k < 8; k++) begin
      start = 1'b1; op = 3'(k); A = $urandom; B = $urandom;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      total++;
      if (hi !== mhi || lo !== mlo || busy !== 1'b0 || done !== 1'b0) begin
        bad++;
        $display("FAIL reserved%0d got=%h_%h %b%b exp=%h_%h 00",
                 k, hi, lo, busy, done, mhi, mlo);
      end
    end
  endtask

  task automatic test_busy_ignore();
    run_op(3'd0, 32'd12345, 32'hfffffff0, 2, 0, "ignore_mult");
    run_op(3'd3, $urandom, $urandom_range(1, 999), 4, 0, "ignore_divu");
  endtask

  task automatic test_back_to_back();
    run_op(3'd2, $urandom, $urandom_range(1, 50), 0, 1, "b2b_first");
    run_op(3'd0, $urandom, $urandom, 0, 0, "b2b_second");
  endtask

  task automatic test_random();
    logic [2:0]  o;
    logic [31:0] a, b;
    for (int i = 0; i < 16; i++) begin
      o = 3'($urandom_range(0, 3));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = '0;
        1: begin a = 32'h80000000; b = 32'hffffffff; end
        2: b = 32'($urandom_range(1, 9));
        3: b = -32'($urandom_range(1, 9));
        default: ;
      endcase
      run_op(o, a, b, 0, 0, "random");
    end
  endtask

  task automatic test_reset_abort();
    start = 1'b1; op = 3'd0; A = 32'd3; B = 32'd5;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1; op = 3'd2; A = $urandom; B = 32'd3;
    @(negedge clk);
    start = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    mhi = '0;
    mlo = '0;
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || hi !== '0 || lo !== '0) begin
      bad++;
      $display("FAIL abort_clear got=%b%b %h_%h exp=00 0_0",
               busy, done, hi, lo);
    end
    @(negedge clk);
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || hi !== '0 || lo !== '0) begin
      bad++;
      $display("FAIL abort_hold got=%b%b %h_%h exp=00 0_0",
               busy, done, hi, lo);
    end
    rst_n = 1'b1;
    run_op(3'd3, 32'd7, 32'd0, 0, 0, "post_reset");
  endtask

  initial begin
    test_reset();
    test_directed();
    test_move();
    test_reserved();
    test_busy_ignore();
    test_back_to_back();
    test_random();
    test_reset_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
